dzcpu_uop_sequencer: RTL and testbench



---
 rtl/dzcpu_uop_sequencer_pkg.sv | 45 ++++
 rtl/dzcpu_uop_sequencer.sv | 151 +++++++++++++++
 tb/tb_dzcpu_uop_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dzcpu_uop_sequencer_pkg.sv
// Shared micro-op encoding for the dzcpu sequencer and its microcode ROM:
// flow-control codes, operation codes, field slices and sequencer states.
package dzcpu_uop_sequencer_pkg;

  // micro-op word layout: [12:9] flow control, [8:4] operation, [3:0] operand
  localparam int UOP_FLOW_HI = 12;
  localparam int UOP_FLOW_LO = 9;
  localparam int UOP_OP_HI   = 8;
  localparam int UOP_OP_LO   = 4;
  localparam int UOP_ARG_HI  = 3;
  localparam int UOP_ARG_LO  = 0;

  localparam logic [3:0] FLOW_OP          = 4'd0;
  localparam logic [3:0] FLOW_INC         = 4'd1;
  localparam logic [3:0] FLOW_EOF         = 4'd2;
  localparam logic [3:0] FLOW_INC_EOF     = 4'd3;
  localparam logic [3:0] FLOW_EOF_FU      = 4'd4;
  localparam logic [3:0] FLOW_INC_EOF_FU  = 4'd5;
  localparam logic [3:0] FLOW_INC_EOF_Z   = 4'd6;
  localparam logic [3:0] FLOW_INC_EOF_NZ  = 4'd7;
  localparam logic [3:0] FLOW_UPD_FLAGS   = 4'd8;
  localparam logic [3:0] FLOW_NOP         = 4'd9;

  localparam logic [4:0] UOP_NOP  = 5'd0;
  localparam logic [4:0] UOP_LD   = 5'd1;
  localparam logic [4:0] UOP_ALU  = 5'd2;
  localparam logic [4:0] UOP_BIT  = 5'd3;
  localparam logic [4:0] UOP_PUSH = 5'd4;
  localparam logic [4:0] UOP_JMP  = 5'd5;
  localparam logic [4:0] UOP_JCB  = 5'd31;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_LOOKUP   = 2'd1,
    S_CBLOOKUP = 2'd2,
    S_EXEC     = 2'd3
  } useq_state_e;

  function automatic logic [12:0] mk_uop(input logic [3:0] flow,
                                         input logic [4:0] op,
                                         input logic [3:0] arg);
    return {flow, op, arg};
  endfunction

endpackage

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-sequencer: latches opcodes, resolves flows via external LUTs and
// walks the microcode ROM one micro-op per cycle. Optional DZCPU_USEQ_WATCHDOG_EN.
module dzcpu_uop_sequencer
  import dzcpu_uop_sequencer_pkg::*;
#(
  parameter int UPC_W    = 8,
  parameter int UOP_W    = 13,
  parameter int WDOG_MAX = 64
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  input  logic             iMopValid,
  input  logic             iStall,
  input  logic             iFlagZ,
  output logic [7:0]       oMop,
  output logic [7:0]       oCbMop,
  input  logic [UPC_W-1:0] iFlowIdx,
  input  logic [UPC_W-1:0] iCbFlowIdx,
  output logic [UPC_W-1:0] oUopAddr,
  input  logic [UOP_W-1:0] iUop,
  output logic [UOP_W-1:0] oUop,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagsUpd,
  output logic             oFetchReq,
  output logic             oError
);

  useq_state_e      state;
  logic [UPC_W-1:0] upc;

  logic [3:0] flow;
  logic [4:0] op;
  logic       dec_valid, dec_pcinc, dec_fu, dec_err, dec_eof, dec_jcb;
  logic       exec_go;
  logic       wdog_trip;

  assign oUopAddr = upc;
  assign exec_go  = (state == S_EXEC) && !iStall;

  // Flow-control decode of the ROM word currently addressed by the micro-PC
  always_comb begin
    flow      = iUop[UOP_FLOW_HI:UOP_FLOW_LO];
    op        = iUop[UOP_OP_HI:UOP_OP_LO];
    dec_valid = 1'b1;
    dec_pcinc = 1'b0;
    dec_fu    = 1'b0;
    dec_err   = 1'b0;
    dec_eof   = 1'b0;
    case (flow)
      FLOW_OP, FLOW_NOP: ;
      FLOW_INC:         dec_pcinc = 1'b1;
      FLOW_EOF:         dec_eof   = 1'b1;
      FLOW_INC_EOF:     begin dec_pcinc = 1'b1; dec_eof = 1'b1; end
      FLOW_EOF_FU:      begin dec_fu    = 1'b1; dec_eof = 1'b1; end
      FLOW_INC_EOF_FU:  begin dec_pcinc = 1'b1; dec_fu = 1'b1; dec_eof = 1'b1; end
      FLOW_INC_EOF_Z: begin
        dec_pcinc = 1'b1;
        if (iFlagZ) begin dec_eof = 1'b1; dec_valid = 1'b0; end
      end
      FLOW_INC_EOF_NZ: begin
        dec_pcinc = 1'b1;
        if (!iFlagZ) begin dec_eof = 1'b1; dec_valid = 1'b0; end
      end
      FLOW_UPD_FLAGS:   dec_fu = 1'b1;
      default: begin dec_eof = 1'b1; dec_err = 1'b1; dec_valid = 1'b0; end
    endcase
    dec_jcb = dec_valid && (op == UOP_JCB);
  end

`ifdef DZCPU_USEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // A CB redirect is not a runaway flow; its counter restarts in S_CBLOOKUP
  assign wdog_trip = exec_go && dec_valid && !dec_eof && !dec_jcb &&
                     (wdog_cnt == WDOG_W'(WDOG_MAX - 1));

  always_ff @(posedge iClock) begin
    if (iReset)
      wdog_cnt <= '0;
    else if (state == S_LOOKUP || state == S_CBLOOKUP)
      wdog_cnt <= '0;
    else if (exec_go && dec_valid)
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state     <= S_FETCH;
      upc       <= '0;
      oMop      <= '0;
      oCbMop    <= '0;
      oUop      <= '0;
      oUopValid <= 1'b0;
      oPcInc    <= 1'b0;
      oFlagsUpd <= 1'b0;
      oFetchReq <= 1'b0;
      oError    <= 1'b0;
    end else begin
      oUopValid <= 1'b0;
      oPcInc    <= 1'b0;
      oFlagsUpd <= 1'b0;
      oError    <= 1'b0;
      case (state)
        S_FETCH: begin
          if (oFetchReq && iMopValid) begin
            oMop      <= iMemData;
            oFetchReq <= 1'b0;
            state     <= S_LOOKUP;
          end else begin
            oFetchReq <= 1'b1;
          end
        end
        S_LOOKUP: begin
          upc   <= iFlowIdx;
          state <= S_EXEC;
        end
        S_CBLOOKUP: begin
          if (!iStall) begin
            upc   <= iCbFlowIdx;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!iStall) begin
            oUop      <= iUop;
            oUopValid <= dec_valid;
            oPcInc    <= dec_pcinc;
            oFlagsUpd <= dec_fu;
            oError    <= dec_err | wdog_trip;
            upc       <= upc + UPC_W'(1);
            if (dec_jcb) begin
              oCbMop <= iMemData;
              state  <= S_CBLOOKUP;
            end else if (dec_eof || wdog_trip) begin
              oFetchReq <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer with a small opcode LUT, CB LUT and
// microcode ROM modelled in the bench.
module tb_dzcpu_uop_sequencer;
  import dzcpu_uop_sequencer_pkg::*;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iMemData = '0;
  logic        iMopValid = 1'b0;
  logic        iStall = 1'b0;
  logic        iFlagZ = 1'b0;
  logic [7:0]  oMop, oCbMop;
  logic [7:0]  iFlowIdx, iCbFlowIdx, oUopAddr;
  logic [12:0] iUop, oUop;
  logic        oUopValid, oPcInc, oFlagsUpd, oFetchReq, oError;
  logic        stub_mode = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 iClock = ~iClock;

  function automatic logic [7:0] lut(input logic [7:0] m);
    case (m)
      8'h00:   return 8'd162;
      8'h20:   return 8'd17;
      8'h21:   return 8'd5;
      8'hCB:   return 8'd15;
      8'hCD:   return 8'd30;
      8'h40:   return 8'd100;
      8'h50:   return 8'd40;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] cblut(input logic [7:0] m);
    return (m == 8'h7C) ? 8'd16 : 8'd0;
  endfunction

  function automatic logic [12:0] rom(input logic [7:0] a);
    case (a)
      8'd162:  return mk_uop(FLOW_INC_EOF,   UOP_NOP,  4'd0);
      8'd17:   return mk_uop(FLOW_INC,       UOP_ALU,  4'd1);
      8'd18:   return mk_uop(FLOW_OP,        UOP_LD,   4'd2);
      8'd19:   return mk_uop(FLOW_INC_EOF_Z, UOP_JMP,  4'd3);
      8'd20:   return mk_uop(FLOW_OP,        UOP_LD,   4'd4);
      8'd21:   return mk_uop(FLOW_INC,       UOP_ALU,  4'd5);
      8'd22:   return mk_uop(FLOW_EOF,       UOP_JMP,  4'd6);
      8'd15:   return mk_uop(FLOW_INC,       UOP_JCB,  4'd0);
      8'd16:   return mk_uop(FLOW_EOF_FU,    UOP_BIT,  4'd7);
      8'd5:    return mk_uop(FLOW_INC,       UOP_LD,   4'd1);
      8'd6:    return mk_uop(FLOW_INC,       UOP_LD,   4'd2);
      8'd7:    return mk_uop(FLOW_OP,        UOP_LD,   4'd3);
      8'd8:    return mk_uop(FLOW_EOF,       UOP_LD,   4'd4);
      8'd30:   return mk_uop(FLOW_INC,       UOP_LD,   4'd0);
      8'd31:   return mk_uop(FLOW_INC,       UOP_LD,   4'd1);
      8'd32:   return mk_uop(FLOW_OP,        UOP_PUSH, 4'd2);
      8'd33:   return mk_uop(FLOW_OP,        UOP_PUSH, 4'd3);
      8'd34:   return mk_uop(FLOW_OP,        UOP_JMP,  4'd4);
      8'd35:   return mk_uop(FLOW_EOF,       UOP_NOP,  4'd0);
      8'd40:   return mk_uop(4'hA,           UOP_NOP,  4'd0);
      default: return mk_uop(FLOW_INC_EOF,   UOP_NOP,  4'd0);
    endcase
  endfunction

  assign iFlowIdx   = lut(oMop);
  assign iCbFlowIdx = cblut(oCbMop);
  assign iUop       = stub_mode ? mk_uop(FLOW_OP, UOP_NOP, 4'd0) : rom(oUopAddr);

  dzcpu_uop_sequencer dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iMemData   (iMemData),
    .iMopValid  (iMopValid),
    .iStall     (iStall),
    .iFlagZ     (iFlagZ),
    .oMop       (oMop),
    .oCbMop     (oCbMop),
    .iFlowIdx   (iFlowIdx),
    .iCbFlowIdx (iCbFlowIdx),
    .oUopAddr   (oUopAddr),
    .iUop       (iUop),
    .oUop       (oUop),
    .oUopValid  (oUopValid),
    .oPcInc     (oPcInc),
    .oFlagsUpd  (oFlagsUpd),
    .oFetchReq  (oFetchReq),
    .oError     (oError)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, oMop, oCbMop, oUopAddr, oUop, oUopValid, oPcInc, oFlagsUpd, oFetchReq, oError};
  endfunction

  // Hands one opcode over while oFetchReq is up; returns in the lookup cycle (N+1)
  task automatic issue(input logic [7:0] opc);
    int w = 0;
    while (!oFetchReq && w < 20) begin
      tick();
      w++;
    end
    chk("fetch_ready", {63'd0, oFetchReq}, 64'd1);
    iMemData  = opc;
    iMopValid = 1'b1;
    tick();
    iMopValid = 1'b0;
  endtask

  // Counts issued micro-ops until the flow hands back to fetch
  task automatic run_flow(input string tag, output int n, output logic [12:0] last);
    n = 0;
    last = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oUopValid) begin
        n++;
        last = oUop;
      end
      if (oFetchReq) break;
    end
    chk(tag, {63'd0, oFetchReq}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;
    logic [12:0] last;
    logic err_seen;

    // reset state
    tick();
    tick();
    chk("rst_outs", all_outs(), 64'd0);
    iReset = 1'b0;
    tick();
    chk("rst_fetchreq", {63'd0, oFetchReq}, 64'd1);

    // NOP: address at N+2, first micro-op at N+3
    issue(8'h00);
    chk("nop_lookup_fetchreq", {63'd0, oFetchReq}, 64'd0);
    tick();
    chk("nop_addr", {56'd0, oUopAddr}, 64'd162);
    chk("nop_valid_early", {63'd0, oUopValid}, 64'd0);
    tick();
    chk("nop_valid", {63'd0, oUopValid}, 64'd1);
    chk("nop_pcinc", {63'd0, oPcInc}, 64'd1);
    chk("nop_fetchreq", {63'd0, oFetchReq}, 64'd1);
    chk("nop_uop", {51'd0, oUop}, {51'd0, mk_uop(FLOW_INC_EOF, UOP_NOP, 4'd0)});

    // JRNZ with Z=1: third micro-op suppressed, flow ends
    iFlagZ = 1'b1;
    issue(8'h20);
    tick();
    chk("jrz_addr", {56'd0, oUopAddr}, 64'd17);
    tick();
    chk("jrz_u17", {50'd0, oUopValid, oUop}, {50'd0, 1'b1, mk_uop(FLOW_INC, UOP_ALU, 4'd1)});
    tick();
    chk("jrz_u18", {50'd0, oUopValid, oUop}, {50'd0, 1'b1, mk_uop(FLOW_OP, UOP_LD, 4'd2)});
    tick();
    chk("jrz_u19_valid", {63'd0, oUopValid}, 64'd0);
    chk("jrz_u19_pcinc", {63'd0, oPcInc}, 64'd1);
    chk("jrz_u19_fetch", {63'd0, oFetchReq}, 64'd1);

    // JRNZ with Z=0: all six micro-ops issued
    iFlagZ = 1'b0;
    issue(8'h20);
    run_flow("jrnz_end", n, last);
    chk("jrnz_count", 64'(n), 64'd6);
    chk("jrnz_last", {51'd0, last}, {51'd0, mk_uop(FLOW_EOF, UOP_JMP, 4'd6)});

    // CB prefix redirect
    issue(8'hCB);
    tick();
    chk("cb_addr", {56'd0, oUopAddr}, 64'd15);
    iMemData = 8'h7C;
    tick();
    chk("cb_mop", {56'd0, oCbMop}, 64'h7C);
    chk("cb_jcb_valid", {62'd0, oUopValid, oPcInc}, 64'd3);
    chk("cb_jcb_nofetch", {63'd0, oFetchReq}, 64'd0);
    tick();
    chk("cb_addr16", {56'd0, oUopAddr}, 64'd16);
    tick();
    chk("cb_bit", {50'd0, oUopValid, oUop}, {50'd0, 1'b1, mk_uop(FLOW_EOF_FU, UOP_BIT, 4'd7)});
    chk("cb_flagsupd", {62'd0, oFlagsUpd, oFetchReq}, 64'd3);

    // LDHLnn stalled three cycles at address 6
    issue(8'h21);
    tick();
    chk("ld_addr5", {56'd0, oUopAddr}, 64'd5);
    tick();
    cnt = oUopValid ? 1 : 0;
    chk("ld_addr6", {56'd0, oUopAddr}, 64'd6);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_stall_addr", {56'd0, oUopAddr}, 64'd6);
      chk("ld_stall_valid", {61'd0, oUopValid, oPcInc, oFlagsUpd}, 64'd0);
    end
    iStall = 1'b0;
    run_flow("ld_end", n, last);
    chk("ld_count", 64'(cnt + n), 64'd4);
    chk("ld_last", {51'd0, last}, {51'd0, mk_uop(FLOW_EOF, UOP_LD, 4'd4)});

    // reserved flow code
    issue(8'h50);
    tick();
    tick();
    chk("rsv_err", {61'd0, oError, oUopValid, oFetchReq}, 64'b101);
    tick();
    chk("rsv_err_pulse", {63'd0, oError}, 64'd0);

    // reset in the middle of CALLnn
    issue(8'hCD);
    tick();
    tick();
    tick();
    tick();
    chk("call_u3", {50'd0, oUopValid, oUop}, {50'd0, 1'b1, mk_uop(FLOW_OP, UOP_PUSH, 4'd2)});
    iReset = 1'b1;
    tick();
    chk("call_rst_outs", all_outs(), 64'd0);
    iReset = 1'b0;
    tick();
    chk("call_rst_fetch", {63'd0, oFetchReq}, 64'd1);
    issue(8'h00);
    tick();
    chk("post_rst_addr", {56'd0, oUopAddr}, 64'd162);
    tick();
    chk("post_rst_nop", {61'd0, oUopValid, oPcInc, oFetchReq}, 64'b111);

    // unterminated flow from a stub ROM
    stub_mode = 1'b1;
    issue(8'h40);
    cnt = 0;
    err_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (oUopValid) cnt++;
      if (oError) begin
        err_seen = 1'b1;
        break;
      end
    end
`ifdef DZCPU_USEQ_WATCHDOG_EN
    chk("wdog_err", {63'd0, err_seen}, 64'd1);
    chk("wdog_count", 64'(cnt), 64'd64);
    chk("wdog_valid_fetch", {62'd0, oUopValid, oFetchReq}, 64'b11);
    tick();
    chk("wdog_pulse", {63'd0, oError}, 64'd0);
`else
    chk("nowdog_err", {63'd0, err_seen}, 64'd0);
    chk("nowdog_fetch", {63'd0, oFetchReq}, 64'd0);
`endif
    stub_mode = 1'b0;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    tick();
    chk("final_fetch", {63'd0, oFetchReq}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
